// File: rtl/ovr_i_pkg.sv
// rtl/ovr_i_pkg.sv - state type and default limits for the over-current shutdown sequencer
package ovr_i_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    TRIP  = 2'd1,
    ARMED = 2'd2
  } ovr_state_t;

  localparam int TRIP_CNT_DFLT = 40;
  localparam int CNT_W_DFLT    = 6;
  localparam int COOL_PER_DFLT = 1024;
  localparam int COOL_W_DFLT   = 11;

endpackage

// File: rtl/ovr_i_synch.sv
// rtl/ovr_i_synch.sv - two-flop synchronizer for one raw asynchronous over-current flag
module ovr_i_synch
  import ovr_i_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/ovr_i_shtdwn_ctrl.sv
// rtl/ovr_i_shtdwn_ctrl.sv - qualifies over-current hits per PWM period, integrates them in a
// leaky counter and holds a latched shutdown through cool-down until an explicit clear
module ovr_i_shtdwn_ctrl
  import ovr_i_pkg::*;
#(
  parameter int TRIP_CNT = TRIP_CNT_DFLT,
  parameter int CNT_W    = CNT_W_DFLT,
  parameter int COOL_PER = COOL_PER_DFLT,
  parameter int COOL_W   = COOL_W_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PWM_synch,
  input  logic             ovr_I_blank,
  input  logic             OVR_I_lft,
  input  logic             OVR_I_rght,
  input  logic             clr_fault,
  output logic             OVR_I_shtdwn,
  output logic             fault_lft,
  output logic             fault_rght,
  output logic [CNT_W-1:0] ovr_cnt
);

  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  TRIP_V  = CNT_W'(TRIP_CNT);
  localparam logic [COOL_W-1:0] COOL_V  = COOL_W'(COOL_PER);

  ovr_state_t        state, state_nxt;
  logic              lft_sync, rght_sync;
  logic              qual_l, qual_r;
  logic              hit_l, hit_r, hit_l_nxt, hit_r_nxt;
  logic              flt_l_nxt, flt_r_nxt;
  logic [CNT_W-1:0]  cnt_nxt, leak_cnt;
  logic [COOL_W-1:0] cool, cool_nxt, cool_inc;

  ovr_i_synch u_sync_lft (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (OVR_I_lft),
    .sync_out (lft_sync)
  );

  ovr_i_synch u_sync_rght (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (OVR_I_rght),
    .sync_out (rght_sync)
  );

  assign qual_l   = lft_sync & ~ovr_I_blank;
  assign qual_r   = rght_sync & ~ovr_I_blank;
  assign cool_inc = cool + COOL_W'(1);

  // A period with a hit on either side counts once; clean periods leak one back.
  always_comb begin
    leak_cnt = ovr_cnt;
    if (hit_l | hit_r) begin
      if (ovr_cnt != CNT_MAX) leak_cnt = ovr_cnt + CNT_W'(1);
    end else begin
      if (ovr_cnt != '0) leak_cnt = ovr_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    hit_l_nxt = hit_l;
    hit_r_nxt = hit_r;
    cnt_nxt   = ovr_cnt;
    cool_nxt  = cool;
    flt_l_nxt = fault_lft;
    flt_r_nxt = fault_rght;
    case (state)
      RUN: begin
        if (PWM_synch) begin
          // Close the old period on flags up to last clk; this clk's sample opens the new one.
          hit_l_nxt = qual_l;
          hit_r_nxt = qual_r;
          cnt_nxt   = leak_cnt;
          flt_l_nxt = fault_lft | hit_l;
          flt_r_nxt = fault_rght | hit_r;
          if (leak_cnt >= TRIP_V) begin
            state_nxt = TRIP;
            hit_l_nxt = 1'b0;
            hit_r_nxt = 1'b0;
          end
        end else begin
          hit_l_nxt = hit_l | qual_l;
          hit_r_nxt = hit_r | qual_r;
        end
      end
      TRIP: begin
        hit_l_nxt = 1'b0;
        hit_r_nxt = 1'b0;
        if (PWM_synch) begin
          cool_nxt = cool_inc;
          if (cool_inc == COOL_V) state_nxt = ARMED;
        end
      end
      ARMED: begin
        hit_l_nxt = 1'b0;
        hit_r_nxt = 1'b0;
        if (clr_fault) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          cool_nxt  = '0;
          flt_l_nxt = 1'b0;
          flt_r_nxt = 1'b0;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_l        <= 1'b0;
      hit_r        <= 1'b0;
      ovr_cnt      <= '0;
      cool         <= '0;
      fault_lft    <= 1'b0;
      fault_rght   <= 1'b0;
      OVR_I_shtdwn <= 1'b0;
    end else begin
      hit_l        <= hit_l_nxt;
      hit_r        <= hit_r_nxt;
      ovr_cnt      <= cnt_nxt;
      cool         <= cool_nxt;
      fault_lft    <= flt_l_nxt;
      fault_rght   <= flt_r_nxt;
      OVR_I_shtdwn <= (state_nxt != RUN);
    end
  end

endmodule

// File: tb/tb_ovr_i_shtdwn_ctrl.sv
// tb/tb_ovr_i_shtdwn_ctrl.sv - bench for ovr_i_shtdwn_ctrl: directed scenarios plus random stimulus
// checked every cycle against a period-level behavioural model
module tb_ovr_i_shtdwn_ctrl;

  localparam int TRIP_CNT = 40;
  localparam int CNT_W    = 6;
  localparam int COOL_PER = 1024;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             PWM_synch = 1'b0;
  logic             ovr_I_blank = 1'b0;
  logic             OVR_I_lft = 1'b0;
  logic             OVR_I_rght = 1'b0;
  logic             clr_fault = 1'b0;
  logic             OVR_I_shtdwn;
  logic             fault_lft;
  logic             fault_rght;
  logic [CNT_W-1:0] ovr_cnt;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  ovr_i_shtdwn_ctrl #(
    .TRIP_CNT (TRIP_CNT),
    .CNT_W    (CNT_W),
    .COOL_PER (COOL_PER),
    .COOL_W   (11)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PWM_synch    (PWM_synch),
    .ovr_I_blank  (ovr_I_blank),
    .OVR_I_lft    (OVR_I_lft),
    .OVR_I_rght   (OVR_I_rght),
    .clr_fault    (clr_fault),
    .OVR_I_shtdwn (OVR_I_shtdwn),
    .fault_lft    (fault_lft),
    .fault_rght   (fault_rght),
    .ovr_cnt      (ovr_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raw flags seen two edges late; per-period "any hit" drives a net up/down score.
  bit lq[$];
  bit rq[$];
  bit m_sl, m_sr;
  bit m_seen_l, m_seen_r;
  bit m_fl, m_fr;
  bit m_tripped, m_armed;
  int m_score, m_periods_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lq = '{1'b0, 1'b0};
      rq = '{1'b0, 1'b0};
      m_seen_l = 0; m_seen_r = 0; m_fl = 0; m_fr = 0;
      m_tripped = 0; m_armed = 0; m_score = 0; m_periods_out = 0;
    end else begin
      m_sl = lq.pop_front();
      m_sr = rq.pop_front();
      lq.push_back(OVR_I_lft);
      rq.push_back(OVR_I_rght);
      if (!m_tripped) begin
        if (PWM_synch) begin
          if (m_seen_l || m_seen_r) m_score = (m_score < CNT_MAX) ? m_score + 1 : CNT_MAX;
          else                      m_score = (m_score > 0) ? m_score - 1 : 0;
          m_fl = m_fl | m_seen_l;
          m_fr = m_fr | m_seen_r;
          m_seen_l = 0;
          m_seen_r = 0;
          if (m_score >= TRIP_CNT) begin
            m_tripped = 1;
            m_periods_out = 0;
          end
        end
        if (!m_tripped) begin
          m_seen_l = m_seen_l | (m_sl && !ovr_I_blank);
          m_seen_r = m_seen_r | (m_sr && !ovr_I_blank);
        end
      end else if (!m_armed) begin
        if (PWM_synch) begin
          m_periods_out++;
          if (m_periods_out == COOL_PER) m_armed = 1;
        end
      end else if (clr_fault) begin
        m_tripped = 0; m_armed = 0; m_score = 0; m_periods_out = 0;
        m_fl = 0; m_fr = 0; m_seen_l = 0; m_seen_r = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_shtdwn", int'(OVR_I_shtdwn), int'(m_tripped));
      check("cyc_cnt", int'(ovr_cnt), m_score);
      check("cyc_fault_lft", int'(fault_lft), int'(m_fl));
      check("cyc_fault_rght", int'(fault_rght), int'(m_fr));
    end
  end

  // 8-clk PWM period: blank on clk 0, raw flag pulse on clks 1..3, period close on clk 7.
  task automatic period(input bit l, input bit r, input bit blank_all, input bit clr);
    for (int c = 0; c < 8; c++) begin
      PWM_synch   = (c == 7);
      ovr_I_blank = blank_all || (c == 0);
      OVR_I_lft   = l && (c >= 1) && (c <= 3);
      OVR_I_rght  = r && (c >= 1) && (c <= 3);
      clr_fault   = clr && (c == 4);
      @(posedge clk); #1;
    end
    PWM_synch = 1'b0;
    clr_fault = 1'b0;
  endtask

  task automatic do_reset();
    PWM_synch = 0; ovr_I_blank = 0; OVR_I_lft = 0; OVR_I_rght = 0; clr_fault = 0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;
    check("rst_shtdwn", int'(OVR_I_shtdwn), 0);
    check("rst_cnt", int'(ovr_cnt), 0);
    check("rst_faults", int'({fault_lft, fault_rght}), 0);

    repeat (45) period(1, 1, 1, 0);
    check("blank_cnt", int'(ovr_cnt), 0);
    check("blank_shtdwn", int'(OVR_I_shtdwn), 0);

    repeat (10) period(1, 0, 0, 0);
    OVR_I_lft = 1'b1;
    repeat (50) begin @(posedge clk); #1; end
    OVR_I_lft = 1'b0;
    check("nosynch_cnt", int'(ovr_cnt), 10);
    check("nosynch_shtdwn", int'(OVR_I_shtdwn), 0);

    do_reset();
    repeat (39) period(1, 0, 0, 0);
    check("l39_cnt", int'(ovr_cnt), 39);
    check("l39_shtdwn", int'(OVR_I_shtdwn), 0);
    period(1, 0, 0, 0);
    check("l40_shtdwn", int'(OVR_I_shtdwn), 1);
    check("l40_cnt", int'(ovr_cnt), 40);
    check("l40_fault_lft", int'(fault_lft), 1);
    check("l40_fault_rght", int'(fault_rght), 0);

    for (int p = 1; p <= 1030; p++) begin
      period((p % 3 == 0) && (p < 1000), (p % 5 == 0) && (p < 1000), 0,
             (p == 500) || (p == 1024) || (p == 1030));
      if (p == 500) begin
        check("clr500_shtdwn", int'(OVR_I_shtdwn), 1);
        check("clr500_cnt", int'(ovr_cnt), 40);
      end
      if (p == 1024) check("clr1024_shtdwn", int'(OVR_I_shtdwn), 1);
      if (p == 1029) check("armed_shtdwn", int'(OVR_I_shtdwn), 1);
    end
    check("clr1030_shtdwn", int'(OVR_I_shtdwn), 0);
    check("clr1030_cnt", int'(ovr_cnt), 0);
    check("clr1030_faults", int'({fault_lft, fault_rght}), 0);

    do_reset();
    for (int i = 0; i < 200; i++) period(0, (i % 2) == 0, 0, 0);
    check("alt_cnt", int'(ovr_cnt), 0);
    check("alt_shtdwn", int'(OVR_I_shtdwn), 0);
    repeat (39) period(0, 1, 0, 0);
    period(0, 0, 0, 0);
    period(0, 1, 0, 0);
    check("net39_cnt", int'(ovr_cnt), 39);
    check("net39_shtdwn", int'(OVR_I_shtdwn), 0);
    period(0, 1, 0, 0);
    check("net40_shtdwn", int'(OVR_I_shtdwn), 1);
    check("net40_fault_rght", int'(fault_rght), 1);
    check("net40_fault_lft", int'(fault_lft), 0);

    do_reset();
    repeat (20) period(1, 1, 0, 0);
    check("both20_cnt", int'(ovr_cnt), 20);
    check("both20_shtdwn", int'(OVR_I_shtdwn), 0);
    repeat (20) period(1, 1, 0, 0);
    check("both40_shtdwn", int'(OVR_I_shtdwn), 1);
    check("both40_faults", int'({fault_lft, fault_rght}), 3);

    #2 rst_n = 1'b0;
    #1 check("async_rst_shtdwn", int'(OVR_I_shtdwn), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("post_rst_cnt", int'(ovr_cnt), 0);
    repeat (40) period(1, 0, 0, 0);
    check("retrip_shtdwn", int'(OVR_I_shtdwn), 1);

    for (int seg = 0; seg < 3; seg++) begin
      int pct;
      pct = (seg == 0) ? 10 : ((seg == 1) ? 40 : 85);
      do_reset();
      for (int k = 0; k < 1200; k++) begin
        PWM_synch   = ($urandom_range(0, 5) == 0);
        ovr_I_blank = ($urandom_range(0, 3) == 0);
        OVR_I_lft   = ($urandom_range(0, 99) < pct);
        OVR_I_rght  = ($urandom_range(0, 99) < pct / 2);
        clr_fault   = ($urandom_range(0, 39) == 0);
        @(posedge clk); #1;
      end
    end

    PWM_synch = 0; ovr_I_blank = 0; OVR_I_lft = 0; OVR_I_rght = 0; clr_fault = 0;
    repeat (2) @(posedge clk);
    #1 cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
